fork_4ph: RTL and testbench

//  Clocked 4-phase (return-to-zero) bundled-data fork. One upstream token
//  (req_in/ack_in + data) is broadcast to two downstream consumers.
//  ack_in_o completes only when both consumers have acknowledged (C-element

---
 rtl/sync_pkg.sv | 12 +
 rtl/sync_ff.sv | 35 +++
 rtl/fork_4ph.sv | 107 ++++++++++
 tb/tb_fork_4ph.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared handshake state types for the synchronised fork and join stages.
// Pure types package: no latency or backpressure of its own.
package sync_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_ACKD,
    F_REL
  } fork_state_e;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchroniser for one handshake level, async reset to 0.
// Latency STAGES edges (0 = straight wire); no backpressure, level passes through.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i | rst_i;
      assign q_o = d_i;
    end else begin : g_chain
      logic [STAGES-1:0] q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q <= '0;
        end else begin
          q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) begin
            q[i] <= q[i-1];
          end
        end
      end

      assign q_o = q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/fork_4ph.sv
// 4-phase bundled-data fork: one upstream token broadcast to two consumers.
// Latency SYNC_STAGES+1 edges input->output; upstream ack waits for both consumer acks.
module fork_4ph
  import sync_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_in_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             ack_in_o,
  output logic             req_out1_o,
  output logic             req_out2_o,
  output logic [WIDTH-1:0] data_out_o,
  input  logic             ack_out1_i,
  input  logic             ack_out2_i,
  output logic             err_o
);

  logic req_s, ack1_s, ack2_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(req_in_i),   .q_o(req_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack1 (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ack_out1_i), .q_o(ack1_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack2 (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(ack_out2_i), .q_o(ack2_s)
  );

  fork_state_e      state_q, state_n;
  logic             rec1_q, rec1_n, rec2_q, rec2_n;
  logic             err_q, err_n;
  logic             cap;
  logic             req_out_q, ack_in_q;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    state_n = state_q;
    rec1_n  = rec1_q;
    rec2_n  = rec2_q;
    err_n   = err_q;
    cap     = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (ack1_s || ack2_s) err_n = 1'b1;
        if (req_s) begin
          state_n = F_REQ;
          cap     = 1'b1;
          rec1_n  = 1'b0;
          rec2_n  = 1'b0;
        end
      end
      F_REQ: begin
        // A consumer dropping its ack before the fork has released is a violation.
        if (!req_s || (rec1_q && !ack1_s) || (rec2_q && !ack2_s)) err_n = 1'b1;
        rec1_n = rec1_q | ack1_s;
        rec2_n = rec2_q | ack2_s;
        if (rec1_n && rec2_n) state_n = F_ACKD;
      end
      F_ACKD: begin
        if (!req_s) begin
          state_n = F_REL;
          rec1_n  = 1'b0;
          rec2_n  = 1'b0;
        end
      end
      F_REL: begin
        rec1_n = rec1_q | ~ack1_s;
        rec2_n = rec2_q | ~ack2_s;
        if (rec1_n && rec2_n) state_n = F_IDLE;
      end
      default: state_n = F_IDLE;
    endcase
  end

  // Outputs are registered from the next state so nothing is decoded after a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= F_IDLE;
      rec1_q    <= 1'b0;
      rec2_q    <= 1'b0;
      err_q     <= 1'b0;
      req_out_q <= 1'b0;
      ack_in_q  <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_n;
      rec1_q    <= rec1_n;
      rec2_q    <= rec2_n;
      err_q     <= err_n;
      req_out_q <= (state_n == F_REQ) || (state_n == F_ACKD);
      ack_in_q  <= (state_n == F_ACKD) || (state_n == F_REL);
      if (cap) data_q <= data_in_i;
    end
  end

  assign req_out1_o = req_out_q;
  assign req_out2_o = req_out_q;
  assign ack_in_o   = ack_in_q;
  assign data_out_o = data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fork_4ph.sv
// Directed + randomized bench for fork_4ph with default and zero-stage synchronisers.
module tb_fork_4ph;

  localparam int W     = 32;
  localparam int LIMIT = 300;
  localparam int NTOK  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with default synchroniser depth
  logic         req_in = 0, ack1 = 0, ack2 = 0;
  logic [W-1:0] data_in = '0;
  logic         ack_in, ro1, ro2, err;
  logic [W-1:0] dout;

  // DUT with synchronisers removed
  logic         req_in_z = 0, ack1_z = 0, ack2_z = 0;
  logic [W-1:0] data_in_z = '0;
  logic         ack_in_z, ro1_z, ro2_z, err_z;
  logic [W-1:0] dout_z;

  fork_4ph #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_in_i(req_in), .data_in_i(data_in),
    .ack_in_o(ack_in), .req_out1_o(ro1), .req_out2_o(ro2), .data_out_o(dout),
    .ack_out1_i(ack1), .ack_out2_i(ack2), .err_o(err)
  );

  fork_4ph #(.WIDTH(W), .SYNC_STAGES(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .req_in_i(req_in_z), .data_in_i(data_in_z),
    .ack_in_o(ack_in_z), .req_out1_o(ro1_z), .req_out2_o(ro2_z), .data_out_o(dout_z),
    .ack_out1_i(ack1_z), .ack_out2_i(ack2_z), .err_o(err_z)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 req_out1, 1 req_out2, 2 ack_in, 3 err
  function automatic logic obs(input int sel, input bit z);
    case (sel)
      0:       obs = z ? ro1_z    : ro1;
      1:       obs = z ? ro2_z    : ro2;
      2:       obs = z ? ack_in_z : ack_in;
      default: obs = z ? err_z    : err;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input bit z, input logic val, output int n);
    n = 0;
    while (obs(sel, z) !== val && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  // Edges from an input change to the output reaching val must equal exp.
  task automatic lat(input string tag, input int sel, input bit z, input logic val, input int exp);
    int n;
    wait_sig(sel, z, val, n);
    chk(tag, n, exp);
  endtask

  // Full token on either DUT; expected latency is synchroniser depth + 1.
  task automatic token(input bit z, input logic [W-1:0] d, input int l, input string pfx);
    if (z) begin data_in_z = d; req_in_z = 1; end
    else   begin data_in   = d; req_in   = 1; end
    lat({pfx, "_req_rise"}, 0, z, 1'b1, l);
    chk({pfx, "_req_eq"}, obs(1, z), 1'b1);
    chk({pfx, "_data"}, z ? dout_z : dout, d);
    if (z) begin ack1_z = 1; ack2_z = 1; end else begin ack1 = 1; ack2 = 1; end
    lat({pfx, "_ack_rise"}, 2, z, 1'b1, l);
    if (z) req_in_z = 0; else req_in = 0;
    lat({pfx, "_req_fall"}, 0, z, 1'b0, l);
    if (z) begin ack1_z = 0; ack2_z = 0; end else begin ack1 = 0; ack2 = 0; end
    lat({pfx, "_ack_fall"}, 2, z, 1'b0, l);
  endtask

  logic [W-1:0] sent[$], rcv1[$], rcv2[$];
  int  mism_cycles, err_cycles, timeouts;
  bit  stream_done;

  task automatic consumer(input int id);
    int n;
    for (int k = 0; k < NTOK; k++) begin
      wait_sig(id - 1, 1'b0, 1'b1, n);
      if (n >= LIMIT) begin timeouts++; return; end
      if (id == 1) rcv1.push_back(dout); else rcv2.push_back(dout);
      repeat ($urandom_range(0, 7)) tick();
      if (id == 1) ack1 = 1; else ack2 = 1;
      wait_sig(id - 1, 1'b0, 1'b0, n);
      if (n >= LIMIT) begin timeouts++; return; end
      repeat ($urandom_range(0, 7)) tick();
      if (id == 1) ack1 = 0; else ack2 = 0;
    end
  endtask

  task automatic producer();
    int n;
    logic [W-1:0] d;
    for (int k = 0; k < NTOK; k++) begin
      d = $urandom;
      sent.push_back(d);
      data_in = d;
      req_in  = 1;
      wait_sig(2, 1'b0, 1'b1, n);
      if (n >= LIMIT) begin timeouts++; return; end
      req_in = 0;
      wait_sig(2, 1'b0, 1'b0, n);
      if (n >= LIMIT) begin timeouts++; return; end
    end
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_ack_in", ack_in, 0);
    chk("rst_req_out", ro1, 0);
    chk("rst_data", dout, 0);
    chk("rst_err", err, 0);
    tick(); tick();
    #3 rst = 0;
    tick();

    // Basic token, 3-edge latency
    token(1'b0, 32'hDEADBEEF, 3, "basic");
    chk("basic_err", err, 0);

    // Skewed acks
    req_in = 1;
    lat("skew_req_rise", 0, 1'b0, 1'b1, 3);
    ack1 = 1;
    repeat (10) tick();
    chk("skew_ack_hold_low", ack_in, 0);
    ack2 = 1;
    lat("skew_ack_rise", 2, 1'b0, 1'b1, 3);
    req_in = 0;
    lat("skew_req_fall", 0, 1'b0, 1'b0, 3);
    ack1 = 0;
    repeat (10) tick();
    chk("skew_ack_hold_high", ack_in, 1);
    ack2 = 0;
    lat("skew_ack_fall", 2, 1'b0, 1'b0, 3);
    chk("skew_err", err, 0);

    // Random stream against per-consumer scoreboards
    mism_cycles = 0; err_cycles = 0; timeouts = 0; stream_done = 0;
    fork
      begin
        fork
          producer();
          consumer(1);
          consumer(2);
        join
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          tick();
          if (ro1 !== ro2) mism_cycles++;
          if (err !== 1'b0) err_cycles++;
        end
      end
    join
    chk("stream_timeouts", timeouts, 0);
    chk("stream_req_equal", mism_cycles, 0);
    chk("stream_err", err_cycles, 0);
    chk("stream_cnt1", rcv1.size(), NTOK);
    chk("stream_cnt2", rcv2.size(), NTOK);
    for (int k = 0; k < NTOK && k < rcv1.size() && k < rcv2.size(); k++) begin
      chk($sformatf("stream_c1_w%0d", k), rcv1[k], sent[k]);
      chk($sformatf("stream_c2_w%0d", k), rcv2[k], sent[k]);
    end

    // Reset asserted in the acknowledged state, between edges
    data_in = 32'h1234_5678; req_in = 1;
    lat("r4_req_rise", 0, 1'b0, 1'b1, 3);
    ack1 = 1; ack2 = 1;
    lat("r4_ack_rise", 2, 1'b0, 1'b1, 3);
    #2 rst = 1;
    #1;
    chk("r4_ack_in_async", ack_in, 0);
    chk("r4_req_out_async", ro1, 0);
    chk("r4_data_async", dout, 0);
    req_in = 0; ack1 = 0; ack2 = 0;
    tick(); tick();
    #3 rst = 0;
    tick();
    token(1'b0, 32'hA5A5_0F0F, 3, "r4_after");

    // Protocol violation: consumer ack while idle
    ack1 = 1;
    lat("viol_err_rise", 3, 1'b0, 1'b1, 3);
    ack1 = 0;
    repeat (6) tick();
    chk("viol_err_sticky", err, 1);
    token(1'b0, 32'hCAFE_F00D, 3, "viol_traffic");
    chk("viol_err_after_traffic", err, 1);
    rst = 1;
    #1;
    chk("viol_err_cleared", err, 0);
    tick();
    #3 rst = 0;
    tick();

    // Zero-stage build: one edge per transition
    token(1'b1, 32'hDEADBEEF, 1, "z");
    chk("z_err", err_z, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
